// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Main control unit of the multicycle MIPS core. A Moore FSM steps
//            each instruction through fetch/decode/execute/memory/writeback
//            and drives every datapath enable and mux select per cycle, plus
//            the 3-bit ALUControl code.
// Ports    : clk, rst_n (async, active low)
//            Opcode[5:0], Funct[5:0]  - from the instruction register
//            Zero                     - ALU zero flag (same cycle)
//            IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//            ALUSrcB[1:0], ALUControl[2:0], PCSrc[1:0], PCEn - datapath ctrl
//            IllegalOp                - one-cycle unsupported opcode/funct flag
//            State[3:0]               - current state, for debug
// Config   : MC_CTRL_BNE_EN - when defined, bne (000101) is decoded to BNEBR.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [3:0] State
);

  // State encodings
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_BNEBR   = 4'd12;

  // Opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // ALU codes
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_branch_ne;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic       w_illegal_op;
  logic       w_illegal_fn;
  logic [2:0] w_alu_fn;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Opcode legality and funct decode (only meaningful in DECODE / EXECUTE)
  // --------------------------------------------------------------------------
  always_comb begin
    w_illegal_op = 1'b0;
    case (Opcode)
      C_OP_RTYPE, C_OP_LW, C_OP_SW, C_OP_BEQ, C_OP_ADDI, C_OP_J: w_illegal_op = 1'b0;
`ifdef MC_CTRL_BNE_EN
      C_OP_BNE: w_illegal_op = 1'b0;
`endif
      default: w_illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_fn     = C_ALU_ADD;
    w_illegal_fn = 1'b0;
    case (Funct)
      6'b100000: w_alu_fn = C_ALU_ADD;
      6'b100010: w_alu_fn = C_ALU_SUB;
      6'b100100: w_alu_fn = C_ALU_AND;
      6'b100101: w_alu_fn = C_ALU_OR;
      6'b101010: w_alu_fn = C_ALU_SLT;
      default: begin
        w_alu_fn     = C_ALU_ADD;
        w_illegal_fn = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          C_OP_LW, C_OP_SW: w_next = S_MEMADR;
          C_OP_RTYPE:       w_next = S_EXECUTE;
          C_OP_BEQ:         w_next = S_BRANCH;
          C_OP_ADDI:        w_next = S_ADDIEX;
          C_OP_J:           w_next = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          C_OP_BNE:         w_next = S_BNEBR;
`endif
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (Opcode == C_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      // Terminal states and any unused encoding (incl. 12 without bne) -> FETCH
      default:   w_next = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    IorD        = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    w_regwrite  = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = C_ALU_ADD;
    PCSrc       = 2'b00;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_branch_ne = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      // Precompute PC + (SignImm<<2) as the branch target
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_alu_fn;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = C_ALU_SUB;
        PCSrc      = 2'b01;
        w_branch   = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEBR: begin
        ALUSrcA     = 1'b1;
        ALUControl  = C_ALU_SUB;
        PCSrc       = 2'b01;
        w_branch_ne = 1'b1;
      end
`endif
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are gated by rst_n so nothing is written while reset is
  // held, even though the state already reads FETCH.
  assign IRWrite   = rst_n & w_irwrite;
  assign RegWrite  = rst_n & w_regwrite;
  assign MemWrite  = rst_n & w_memwrite;
  assign PCEn      = rst_n & (w_pcwrite | (w_branch & Zero) | (w_branch_ne & ~Zero));
  assign IllegalOp = rst_n & (((r_state == S_DECODE) & w_illegal_op) |
                              ((r_state == S_EXECUTE) & w_illegal_fn));
  assign State     = r_state;

endmodule
`default_nettype wire
